audiodac_fifo_mc: RTL and testbench
===================================

AUDIODAC_FIFO_MC -- requirements
Module: audiodac_fifo_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample bitwidth per channel (unsigned, offset binary).
REQ-002 SHALL have parameter CHANNELS, default 2: channels per frame. One frame is CHANNELS*WIDTH bits, with channel 0 in the LSBs.
REQ-003 SHALL have parameter DEPTH_LOG2, default 5: capacity is 2^DEPTH_LOG2 frames.
REQ-004 SHALL have parameter FIFO_ASYNC, default 1: 1 = fifo_indata_rdy_i is asynchronous; 0 = it is synchronous to clk_i.
REQ-005 SHALL have parameter AFULL_THR, default 24: almost-full threshold, in frames.
REQ-006 SHALL have parameter AEMPTY_THR, default 8: almost-empty threshold, in frames.
REQ-007 SHALL have ports as listed; one clock; reset is synchronous and active-high:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- fifo_indata_i  in  CHANNELS*WIDTH  write frame; held stable while rdy is high.
- fifo_indata_rdy_i  in  1  source request (4-phase).
- fifo_indata_ack_o  out  1  frame accepted.
- fifo_outdata_o  out  CHANNELS*WIDTH  head frame, or held frame when empty.
- fifo_outdata_rd_i  in  1  pop request, one pop per high cycle.
- fifo_full_o  out  1  level == 2^DEPTH_LOG2.
- fifo_empty_o  out  1  level == 0.
- fifo_afull_o  out  1  level >= AFULL_THR.
- fifo_aempty_o  out  1  level <= AEMPTY_THR.
- fifo_level_o  out  DEPTH_LOG2+1  frames stored.
- fifo_underrun_o  out  1  sticky underrun flag.
- underrun_clr_i  in  1  clears the underrun flag.
- tst_fifo_loop_i  in  1  loop test mode.

Function
REQ-008 SHALL use read and write pointers of DEPTH_LOG2+1 bits with the MSB as wrap bit, so all 2^DEPTH_LOG2 entries are usable; level = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
REQ-009 SHALL derive full, empty, afull, aempty and level combinationally from the registered pointers only.
REQ-010 SHALL, when FIFO_ASYNC=1, pass fifo_indata_rdy_i through a 2-flop synchronizer to form rdy_s; when FIFO_ASYNC=0, rdy_s = fifo_indata_rdy_i. Data SHALL NOT be synchronized; it is sampled directly when the write occurs.
REQ-011 SHALL write a frame when rdy_s && !ack && !full: store at wr_ptr, wr_ptr+1, ack<=1 on the next edge.
REQ-012 SHALL clear ack on the edge after rdy_s is seen low; ack stays high while rdy_s stays high, so exactly one write occurs per request.
REQ-013 SHALL have rdy-to-ack latency of 3 clk_i edges when FIFO_ASYNC=1 and 1 edge when FIFO_ASYNC=0, FIFO not full.
REQ-014 SHALL, if full, stall the write with ack low until a pop frees an entry, then write per REQ-011.
REQ-015 SHALL present fifo_outdata_o = store[rd_ptr] when not empty, and hold_reg when empty.
REQ-016 SHALL, on fifo_outdata_rd_i && !empty (normal mode), load hold_reg with the popped frame and increment rd_ptr.
REQ-017 SHALL, on fifo_outdata_rd_i && empty (normal mode), leave rd_ptr unchanged and set fifo_underrun_o.
REQ-018 SHALL keep fifo_underrun_o set until underrun_clr_i is high. If a set and a clear occur in the same cycle, set wins.
REQ-019 SHALL allow a write and a pop in the same cycle; level is then unchanged. A write into an empty FIFO is not poppable in that same cycle; the pop counts as an underrun.
REQ-020 SHALL, in loop mode (tst_fifo_loop_i=1):
- advance only the low DEPTH_LOG2 rd_ptr bits on every pop, wrapping modulo 2^DEPTH_LOG2, regardless of empty;
- output store[rd_ptr] directly;
- suppress underrun;
- block writes.
REQ-021 SHALL, on the first cycle after tst_fifo_loop_i falls, set rd_ptr <= wr_ptr (flush), giving empty=1.
REQ-022 SHALL treat pop requests and writes as ignored during reset.

Reset
REQ-023 SHALL, when rst_i=1 at a clk_i edge, set:
- wr_ptr = rd_ptr = 0;
- ack = 0;
- synchronizer flops = 0;
- fifo_underrun_o = 0;
- loop-edge flop = 0;
- hold_reg = midscale (1<<(WIDTH-1)) in every channel.
REQ-024 SHALL give, after reset: fifo_outdata_o = midscale on all channels, empty=1, full=0, aempty=1, afull=0 (since AFULL_THR>0), level=0.
REQ-025 SHALL discard an in-flight handshake on reset mid-operation; the source must drop rdy and re-request. Storage contents need no reset.

Structure
REQ-026 SHALL take the midscale constant function and the default WIDTH/CHANNELS values from shared package audiodac_pkg.
REQ-027 SHALL instantiate sub-module audiodac_sync2 (2-flop synchronizer) for rdy when FIFO_ASYNC=1.
REQ-028 SHALL check at elaboration that AEMPTY_THR < AFULL_THR <= 2^DEPTH_LOG2.

Verification
REQ-029 SHALL cover reset: after reset, out = 0x8000_8000 (defaults), empty=1, level=0; rdy pulse with data 0x1234_ABCD, FIFO_ASYNC=1 -> ack at edge 3, level=1, out=0x1234_ABCD.
REQ-030 SHALL cover fill: 32 writes -> full=1, level=32, afull=1 from level 24; 33rd rdy -> ack held low until one pop, then ack and level=32.
REQ-031 SHALL cover underrun: pop frames A then B, then pop while empty -> out stays B, underrun=1 until underrun_clr_i, rd_ptr unchanged.
REQ-032 SHALL cover simultaneous write+pop at level 5 -> level stays 5, data order preserved across a 64-frame stream including pointer wrap.
REQ-033 SHALL cover loop mode: write 3 frames, enter loop, 40 pops -> output cycles store[0..31] repeatedly, no underrun, writes blocked; exit loop -> empty=1 next cycle.
REQ-034 SHALL cover FIFO_ASYNC=0 instance: ack 1 edge after rdy; rst_i asserted while ack=1 -> ack=0, level=0 after that edge.

Source files
------------

// File: rtl/audiodac_pkg.sv
// Shared audio DAC definitions: default sample width, channel count and the
// offset-binary midscale (silence) frame builder.
// Latency: n/a (package). Backpressure: n/a.
package audiodac_pkg;

  localparam int AUDIODAC_WIDTH     = 16;
  localparam int AUDIODAC_CHANNELS  = 2;
  // Widest frame the midscale helper can build; users cast down to their width.
  localparam int AUDIODAC_MAX_FRAME = 256;

  typedef logic [AUDIODAC_MAX_FRAME-1:0] audiodac_frame_t;

  // Offset-binary silence: only the MSB of every channel is set.
  function automatic audiodac_frame_t midscale(input int width, input int channels);
    audiodac_frame_t f;
    f = '0;
    for (int c = 0; c < channels; c++) begin
      f = f | (audiodac_frame_t'(1) << (c * width + width - 1));
    end
    return f;
  endfunction

endpackage

// File: rtl/audiodac_fifo_mc_if.sv
// Bus bundle for the audio DAC sample FIFO: 4-phase write handshake, pop
// strobe, status flags, underrun control and loop test mode.
// Ports: slave = FIFO side, master = source/sink side.
interface audiodac_fifo_mc_if
  import audiodac_pkg::*;
#(
  parameter int WIDTH      = AUDIODAC_WIDTH,
  parameter int CHANNELS   = AUDIODAC_CHANNELS,
  parameter int DEPTH_LOG2 = 5
);

  logic [CHANNELS*WIDTH-1:0] fifo_indata_i;
  logic                      fifo_indata_rdy_i;
  logic                      fifo_indata_ack_o;
  logic [CHANNELS*WIDTH-1:0] fifo_outdata_o;
  logic                      fifo_outdata_rd_i;
  logic                      fifo_full_o;
  logic                      fifo_empty_o;
  logic                      fifo_afull_o;
  logic                      fifo_aempty_o;
  logic [DEPTH_LOG2:0]       fifo_level_o;
  logic                      fifo_underrun_o;
  logic                      underrun_clr_i;
  logic                      tst_fifo_loop_i;

  modport slave (
    input  fifo_indata_i, fifo_indata_rdy_i, fifo_outdata_rd_i,
           underrun_clr_i, tst_fifo_loop_i,
    output fifo_indata_ack_o, fifo_outdata_o, fifo_full_o, fifo_empty_o,
           fifo_afull_o, fifo_aempty_o, fifo_level_o, fifo_underrun_o
  );

  modport master (
    output fifo_indata_i, fifo_indata_rdy_i, fifo_outdata_rd_i,
           underrun_clr_i, tst_fifo_loop_i,
    input  fifo_indata_ack_o, fifo_outdata_o, fifo_full_o, fifo_empty_o,
           fifo_afull_o, fifo_aempty_o, fifo_level_o, fifo_underrun_o
  );

endinterface

// File: rtl/audiodac_sync2.sv
// Two-flop synchronizer for a single-bit level signal into clk_i.
// Latency: 2 clk_i edges. Backpressure: none.
// Ports: clk_i, rst_i (sync, active-high), d_i async input, q_o synchronized.
module audiodac_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audiodac_fifo_mc.sv
// Audio sample-frame FIFO with 4-phase write handshake, pop strobe, status
// flags, sticky underrun and a loop test mode that replays the whole store.
// Latency: rdy->ack 3 edges (FIFO_ASYNC=1) or 1 edge (FIFO_ASYNC=0); pop is
//   visible on fifo_outdata_o the cycle after the popping edge.
// Backpressure: when full the write stalls with ack low until a pop frees an
//   entry; pops on empty are dropped and flagged as underrun.
// Ports: clk_i, rst_i (sync, active-high), bus (audiodac_fifo_mc_if.slave).
module audiodac_fifo_mc
  import audiodac_pkg::*;
#(
  parameter int WIDTH      = AUDIODAC_WIDTH,
  parameter int CHANNELS   = AUDIODAC_CHANNELS,
  parameter int DEPTH_LOG2 = 5,
  parameter int FIFO_ASYNC = 1,
  parameter int AFULL_THR  = 24,
  parameter int AEMPTY_THR = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  audiodac_fifo_mc_if.slave  bus
);

  localparam int FW    = CHANNELS * WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] LVL_FULL   = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_AFULL  = PW'(AFULL_THR);
  localparam logic [PW-1:0] LVL_AEMPTY = PW'(AEMPTY_THR);
  localparam logic [FW-1:0] MIDSCALE   = FW'(midscale(WIDTH, CHANNELS));

  if (!(AEMPTY_THR < AFULL_THR && AFULL_THR <= DEPTH)) begin : g_bad_thr
    $error("audiodac_fifo_mc: thresholds must satisfy AEMPTY_THR < AFULL_THR <= 2**DEPTH_LOG2");
  end
  if (FW > AUDIODAC_MAX_FRAME) begin : g_bad_frame
    $error("audiodac_fifo_mc: CHANNELS*WIDTH exceeds AUDIODAC_MAX_FRAME");
  end

  logic [FW-1:0]         store [DEPTH];
  logic [FW-1:0]         hold_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         level;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  ack_q;
  logic                  underrun_q;
  logic                  loop_q;
  logic                  rdy_s;
  logic                  empty;
  logic                  full;
  logic                  loop_mode;
  logic                  loop_exit;
  logic                  wr_en;
  logic                  pop_en;
  logic                  loop_pop;
  logic                  underrun_set;

  // Only the request is synchronized; data is guaranteed stable while rdy is
  // high, so it is sampled straight from the pins at the write edge.
  if (FIFO_ASYNC != 0) begin : g_rdy_sync
    audiodac_sync2 u_rdy_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (bus.fifo_indata_rdy_i),
      .q_o   (rdy_s)
    );
  end else begin : g_rdy_direct
    assign rdy_s = bus.fifo_indata_rdy_i;
  end

  assign wr_addr   = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_addr   = rd_ptr[DEPTH_LOG2-1:0];
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign loop_mode = bus.tst_fifo_loop_i;
  assign loop_exit = loop_q && !loop_mode;

  // The flush cycle on loop exit takes neither writes nor pops so that the
  // FIFO is guaranteed empty on the following cycle.
  assign wr_en        = !rst_i && rdy_s && !ack_q && !full && !loop_mode && !loop_exit;
  assign pop_en       = bus.fifo_outdata_rd_i && !loop_mode && !loop_exit && !empty;
  assign loop_pop     = bus.fifo_outdata_rd_i && loop_mode;
  assign underrun_set = bus.fifo_outdata_rd_i && !loop_mode && empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ack_q      <= 1'b0;
      underrun_q <= 1'b0;
      loop_q     <= 1'b0;
      hold_q     <= MIDSCALE;
    end else begin
      loop_q <= loop_mode;

      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      if (loop_exit) begin
        rd_ptr <= wr_ptr;
      end else if (loop_pop) begin
        // Loop replay walks the raw store; the wrap bit is left alone so the
        // flush on exit is the only thing that restores a sane level.
        rd_ptr <= {rd_ptr[PW-1], rd_addr + DEPTH_LOG2'(1)};
      end else if (pop_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (pop_en) begin
        hold_q <= store[rd_addr];
      end

      // ack stays high for as long as the request does: one write per request.
      if (wr_en) begin
        ack_q <= 1'b1;
      end else if (!rdy_s) begin
        ack_q <= 1'b0;
      end

      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (bus.underrun_clr_i) begin
        underrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      store[wr_addr] <= bus.fifo_indata_i;
    end
  end

  // When empty the last popped frame is repeated so the DAC holds its level.
  assign bus.fifo_outdata_o    = (loop_mode || !empty) ? store[rd_addr] : hold_q;
  assign bus.fifo_indata_ack_o = ack_q;
  assign bus.fifo_full_o       = full;
  assign bus.fifo_empty_o      = empty;
  assign bus.fifo_afull_o      = (level >= LVL_AFULL);
  assign bus.fifo_aempty_o     = (level <= LVL_AEMPTY);
  assign bus.fifo_level_o      = level;
  assign bus.fifo_underrun_o   = underrun_q;

endmodule

// File: tb/tb_audiodac_fifo_mc.sv
// Directed bench for audiodac_fifo_mc: one FIFO_ASYNC=1 instance (dut_a) and
// one FIFO_ASYNC=0 instance (dut_b) driven from a single linear sequence.
module tb_audiodac_fifo_mc;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  audiodac_fifo_mc_if #(.WIDTH(16), .CHANNELS(2), .DEPTH_LOG2(5)) ia ();
  audiodac_fifo_mc_if #(.WIDTH(16), .CHANNELS(2), .DEPTH_LOG2(5)) ib ();

  audiodac_fifo_mc #(.FIFO_ASYNC(1)) dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ia));
  audiodac_fifo_mc #(.FIFO_ASYNC(0)) dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ib));

  localparam logic [31:0] MID = 32'h8000_8000;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] mem [32];
  int          wp = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_pop = MID;
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_wr(input logic [31:0] d);
    mem[wp % 32] = d;
    wp++;
    exp_q.push_back(d);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    wp = 0;
    exp_q.delete();
    last_pop = MID;
  endtask

  // Full 4-phase write on dut_a; checks rdy->ack and rdy-low->ack-low latency.
  task automatic wr_a(input logic [31:0] d);
    int n;
    ia.fifo_indata_i = d;
    ia.fifo_indata_rdy_i = 1'b1;
    n = 0;
    while (ia.fifo_indata_ack_o !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("wr_ack_latency", 64'(n), 64'd3);
    model_wr(d);
    ia.fifo_indata_rdy_i = 1'b0;
    n = 0;
    while (ia.fifo_indata_ack_o !== 1'b0 && n < 16) begin
      tick();
      n++;
    end
    chk("wr_ack_release", 64'(n), 64'd3);
  endtask

  task automatic pop_a(input string tag);
    exp_v = exp_q.pop_front();
    chk(tag, 64'(ia.fifo_outdata_o), 64'(exp_v));
    last_pop = exp_v;
    ia.fifo_outdata_rd_i = 1'b1;
    tick();
    ia.fifo_outdata_rd_i = 1'b0;
  endtask

  initial begin
    ia.fifo_indata_i = '0; ia.fifo_indata_rdy_i = 1'b0; ia.fifo_outdata_rd_i = 1'b0;
    ia.underrun_clr_i = 1'b0; ia.tst_fifo_loop_i = 1'b0;
    ib.fifo_indata_i = '0; ib.fifo_indata_rdy_i = 1'b0; ib.fifo_outdata_rd_i = 1'b0;
    ib.underrun_clr_i = 1'b0; ib.tst_fifo_loop_i = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // ---- reset state
    chk("rst_out",    64'(ia.fifo_outdata_o), 64'(MID));
    chk("rst_empty",  64'(ia.fifo_empty_o), 64'd1);
    chk("rst_full",   64'(ia.fifo_full_o), 64'd0);
    chk("rst_aempty", 64'(ia.fifo_aempty_o), 64'd1);
    chk("rst_afull",  64'(ia.fifo_afull_o), 64'd0);
    chk("rst_level",  64'(ia.fifo_level_o), 64'd0);
    chk("rst_unrun",  64'(ia.fifo_underrun_o), 64'd0);
    chk("rst_ack",    64'(ia.fifo_indata_ack_o), 64'd0);
    chk("rst_b_out",  64'(ib.fifo_outdata_o), 64'(MID));

    // ---- synchronous instance: 1-edge ack, write+pop into empty, reset mid-handshake
    ib.fifo_indata_i = 32'h0BAD_F00D; ib.fifo_indata_rdy_i = 1'b1;
    tick();
    chk("b_ack_1edge", 64'(ib.fifo_indata_ack_o), 64'd1);
    chk("b_level1",    64'(ib.fifo_level_o), 64'd1);
    chk("b_out1",      64'(ib.fifo_outdata_o), 64'h0BAD_F00D);
    ib.fifo_indata_rdy_i = 1'b0;
    tick();
    chk("b_ack_drop",  64'(ib.fifo_indata_ack_o), 64'd0);
    ib.fifo_outdata_rd_i = 1'b1;
    tick();
    ib.fifo_outdata_rd_i = 1'b0;
    chk("b_pop_empty", 64'(ib.fifo_empty_o), 64'd1);
    chk("b_hold",      64'(ib.fifo_outdata_o), 64'h0BAD_F00D);
    ib.fifo_indata_i = 32'hEEEE_0001; ib.fifo_indata_rdy_i = 1'b1; ib.fifo_outdata_rd_i = 1'b1;
    tick();
    ib.fifo_outdata_rd_i = 1'b0;
    chk("b_wrpop_ack",  64'(ib.fifo_indata_ack_o), 64'd1);
    chk("b_wrpop_lvl",  64'(ib.fifo_level_o), 64'd1);
    chk("b_wrpop_unrn", 64'(ib.fifo_underrun_o), 64'd1);
    chk("b_wrpop_out",  64'(ib.fifo_outdata_o), 64'hEEEE_0001);
    ib.fifo_indata_rdy_i = 1'b0;
    tick();
    ib.fifo_indata_i = 32'hFFFF_0002; ib.fifo_indata_rdy_i = 1'b1;
    tick();
    chk("b_pre_rst_ack", 64'(ib.fifo_indata_ack_o), 64'd1);
    chk("b_pre_rst_lvl", 64'(ib.fifo_level_o), 64'd2);
    rst_b = 1'b1;
    tick();
    chk("b_rst_ack",   64'(ib.fifo_indata_ack_o), 64'd0);
    chk("b_rst_lvl",   64'(ib.fifo_level_o), 64'd0);
    chk("b_rst_empty", 64'(ib.fifo_empty_o), 64'd1);
    chk("b_rst_unrn",  64'(ib.fifo_underrun_o), 64'd0);
    chk("b_rst_out",   64'(ib.fifo_outdata_o), 64'(MID));
    ib.fifo_indata_rdy_i = 1'b0;
    rst_b = 1'b0;
    tick();
    chk("b_post_ack",  64'(ib.fifo_indata_ack_o), 64'd0);
    chk("b_post_lvl",  64'(ib.fifo_level_o), 64'd0);

    // ---- first write through the synchronizer
    wr_a(32'h1234_ABCD);
    chk("w1_level", 64'(ia.fifo_level_o), 64'd1);
    chk("w1_out",   64'(ia.fifo_outdata_o), 64'h1234_ABCD);
    chk("w1_empty", 64'(ia.fifo_empty_o), 64'd0);

    // ---- fill to full, threshold edges, stalled 33rd write
    reset_a();
    for (int i = 1; i <= 32; i++) begin
      wr_a(32'hA000_0000 | 32'(i));
      if (i == 8)  chk("aempty_at8",  64'(ia.fifo_aempty_o), 64'd1);
      if (i == 9)  chk("aempty_at9",  64'(ia.fifo_aempty_o), 64'd0);
      if (i == 23) chk("afull_at23",  64'(ia.fifo_afull_o), 64'd0);
      if (i == 24) chk("afull_at24",  64'(ia.fifo_afull_o), 64'd1);
      if (i == 31) chk("full_at31",   64'(ia.fifo_full_o), 64'd0);
    end
    chk("fill_full",  64'(ia.fifo_full_o), 64'd1);
    chk("fill_level", 64'(ia.fifo_level_o), 64'd32);
    ia.fifo_indata_i = 32'hDEAD_0033; ia.fifo_indata_rdy_i = 1'b1;
    repeat (8) tick();
    chk("stall_ack",   64'(ia.fifo_indata_ack_o), 64'd0);
    chk("stall_level", 64'(ia.fifo_level_o), 64'd32);
    pop_a("stall_pop_head");
    chk("stall_lvl31", 64'(ia.fifo_level_o), 64'd31);
    tick();
    chk("stall_ack_go", 64'(ia.fifo_indata_ack_o), 64'd1);
    chk("stall_lvl32",  64'(ia.fifo_level_o), 64'd32);
    model_wr(32'hDEAD_0033);
    ia.fifo_indata_rdy_i = 1'b0;
    repeat (3) tick();
    chk("stall_ack_rel", 64'(ia.fifo_indata_ack_o), 64'd0);
    for (int i = 0; i < 32; i++) pop_a("drain_order");
    chk("drain_empty", 64'(ia.fifo_empty_o), 64'd1);
    chk("drain_hold",  64'(ia.fifo_outdata_o), 64'hDEAD_0033);

    // ---- underrun: pop A, pop B, pop on empty
    wr_a(32'hAAAA_0001);
    wr_a(32'hBBBB_0002);
    pop_a("ur_pop_a");
    pop_a("ur_pop_b");
    chk("ur_hold_b", 64'(ia.fifo_outdata_o), 64'hBBBB_0002);
    ia.fifo_outdata_rd_i = 1'b1;
    tick();
    ia.fifo_outdata_rd_i = 1'b0;
    chk("ur_set",   64'(ia.fifo_underrun_o), 64'd1);
    chk("ur_out_b", 64'(ia.fifo_outdata_o), 64'hBBBB_0002);
    chk("ur_level", 64'(ia.fifo_level_o), 64'd0);
    repeat (3) tick();
    chk("ur_sticky", 64'(ia.fifo_underrun_o), 64'd1);
    ia.underrun_clr_i = 1'b1;
    tick();
    ia.underrun_clr_i = 1'b0;
    chk("ur_clr", 64'(ia.fifo_underrun_o), 64'd0);
    ia.underrun_clr_i = 1'b1; ia.fifo_outdata_rd_i = 1'b1;
    tick();
    ia.underrun_clr_i = 1'b0; ia.fifo_outdata_rd_i = 1'b0;
    chk("ur_set_wins", 64'(ia.fifo_underrun_o), 64'd1);
    ia.underrun_clr_i = 1'b1;
    tick();
    ia.underrun_clr_i = 1'b0;
    chk("ur_clr2", 64'(ia.fifo_underrun_o), 64'd0);
    wr_a(32'hCCCC_0003);
    chk("ur_rdptr_lvl", 64'(ia.fifo_level_o), 64'd1);
    chk("ur_rdptr_out", 64'(ia.fifo_outdata_o), 64'hCCCC_0003);
    pop_a("ur_pop_c");

    // ---- simultaneous write+pop at level 5 over a 64-frame stream
    for (int k = 0; k < 5; k++) wr_a(32'hC000_0000 | 32'(k));
    chk("sim_prime_lvl", 64'(ia.fifo_level_o), 64'd5);
    for (int k = 5; k < 64; k++) begin
      ia.fifo_indata_i = 32'hC000_0000 | 32'(k);
      ia.fifo_indata_rdy_i = 1'b1;
      tick();
      tick();
      exp_v = exp_q.pop_front();
      chk("sim_head", 64'(ia.fifo_outdata_o), 64'(exp_v));
      ia.fifo_outdata_rd_i = 1'b1;
      tick();
      ia.fifo_outdata_rd_i = 1'b0;
      chk("sim_ack",   64'(ia.fifo_indata_ack_o), 64'd1);
      chk("sim_level", 64'(ia.fifo_level_o), 64'd5);
      model_wr(32'hC000_0000 | 32'(k));
      ia.fifo_indata_rdy_i = 1'b0;
      repeat (3) tick();
    end
    for (int k = 0; k < 5; k++) pop_a("sim_tail");
    chk("sim_empty", 64'(ia.fifo_empty_o), 64'd1);

    // ---- loop mode replay of the whole store
    reset_a();
    wr_a(32'h1100_0000);
    wr_a(32'h1100_0001);
    wr_a(32'h1100_0002);
    ia.tst_fifo_loop_i = 1'b1;
    tick();
    chk("loop_out0", 64'(ia.fifo_outdata_o), 64'(mem[0]));
    ia.fifo_indata_i = 32'h9999_9999; ia.fifo_indata_rdy_i = 1'b1;
    repeat (6) tick();
    chk("loop_wr_blk_ack", 64'(ia.fifo_indata_ack_o), 64'd0);
    chk("loop_wr_blk_lvl", 64'(ia.fifo_level_o), 64'd3);
    ia.fifo_indata_rdy_i = 1'b0;
    repeat (3) tick();
    ia.fifo_outdata_rd_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("loop_replay", 64'(ia.fifo_outdata_o), 64'(mem[i % 32]));
      tick();
    end
    ia.fifo_outdata_rd_i = 1'b0;
    chk("loop_no_unrn", 64'(ia.fifo_underrun_o), 64'd0);
    ia.tst_fifo_loop_i = 1'b0;
    tick();
    chk("loop_exit_empty", 64'(ia.fifo_empty_o), 64'd1);
    chk("loop_exit_level", 64'(ia.fifo_level_o), 64'd0);
    chk("loop_exit_out",   64'(ia.fifo_outdata_o), 64'(MID));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
